// File: rtl/debug_apb_arbiter_if.sv
// Requester-side handshakes and APB master bus of the debug APB arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface debug_apb_arbiter_if #(
   parameter int ADDR_W = 5
);
   logic              req0_valid;
   logic              req0_write;
   logic [ADDR_W-1:0] req0_addr;
   logic [7:0]        req0_wdata;
   logic              req0_ready;
   logic              rsp0_valid;
   logic              rsp0_err;
   logic [7:0]        rsp0_rdata;

   logic              req1_valid;
   logic              req1_write;
   logic [ADDR_W-1:0] req1_addr;
   logic [7:0]        req1_wdata;
   logic              req1_ready;
   logic              rsp1_valid;
   logic              rsp1_err;
   logic [7:0]        rsp1_rdata;

   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [7:0]        PWDATA;
   logic [7:0]        PRDATA;
   logic              PREADY;

   modport master (
      input  req0_valid, req0_write, req0_addr, req0_wdata,
      output req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
      input  req1_valid, req1_write, req1_addr, req1_wdata,
      output req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY
   );

   modport slave (
      output req0_valid, req0_write, req0_addr, req0_wdata,
      input  req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
      output req1_valid, req1_write, req1_addr, req1_wdata,
      input  req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY
   );
endinterface

// File: rtl/debug_apb_arbiter.sv
// Round-robin two-requester APB master, one SETUP/ACCESS transfer at a time.
// Zero-wait transfer: ready 1 cycle, response 3 cycles after grant; slave stalls via PREADY, aborted after TIMEOUT.
module debug_apb_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 5
) (
   input logic                 PCLK,
   input logic                 PRESETn,
   debug_apb_arbiter_if.master bus
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t            state, state_nxt;
   logic              last_grant;
   logic              grant;
   logic              grant_nxt;
   logic [CW-1:0]     wait_cnt;
   logic              start;
   logic              timeout_hit;
   logic              done;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [7:0]        sel_wdata;
   logic [7:0]        rdata_cap;

   always_comb begin
      state_nxt   = state;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;

      // With both requesting, the one not served last wins.
      if (bus.req0_valid && bus.req1_valid) begin
         grant_nxt = ~last_grant;
      end else begin
         grant_nxt = bus.req1_valid;
      end
      sel_write = grant_nxt ? bus.req1_write : bus.req0_write;
      sel_addr  = grant_nxt ? bus.req1_addr  : bus.req0_addr;
      sel_wdata = grant_nxt ? bus.req1_wdata : bus.req0_wdata;

      start       = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
      timeout_hit = (TIMEOUT > 0) && !bus.PREADY && ((int'(wait_cnt) + 1) >= TIMEOUT);
      done        = bus.PREADY || timeout_hit;
      rdata_cap   = (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : 8'h00;

      case (state)
         IDLE: begin
            if (start) state_nxt = SETUP;
         end
         SETUP: begin
            bus.PSEL       = 1'b1;
            bus.req0_ready = ~grant;
            bus.req1_ready = grant;
            state_nxt      = ACCESS;
         end
         ACCESS: begin
            bus.PSEL    = 1'b1;
            bus.PENABLE = 1'b1;
            if (done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state          <= IDLE;
         last_grant     <= 1'b1;
         grant          <= 1'b0;
         wait_cnt       <= '0;
         bus.PWRITE     <= 1'b0;
         bus.PADDR      <= '0;
         bus.PWDATA     <= '0;
         bus.rsp0_valid <= 1'b0;
         bus.rsp0_err   <= 1'b0;
         bus.rsp0_rdata <= '0;
         bus.rsp1_valid <= 1'b0;
         bus.rsp1_err   <= 1'b0;
         bus.rsp1_rdata <= '0;
      end else begin
         state          <= state_nxt;
         bus.rsp0_valid <= 1'b0;
         bus.rsp0_err   <= 1'b0;
         bus.rsp0_rdata <= '0;
         bus.rsp1_valid <= 1'b0;
         bus.rsp1_err   <= 1'b0;
         bus.rsp1_rdata <= '0;

         if (start) begin
            grant      <= grant_nxt;
            last_grant <= grant_nxt;
            bus.PWRITE <= sel_write;
            bus.PADDR  <= sel_addr;
            bus.PWDATA <= sel_wdata;
            wait_cnt   <= '0;
         end

         if (state == ACCESS) begin
            if (done) begin
               if (grant) begin
                  bus.rsp1_valid <= 1'b1;
                  bus.rsp1_err   <= ~bus.PREADY;
                  bus.rsp1_rdata <= rdata_cap;
               end else begin
                  bus.rsp0_valid <= 1'b1;
                  bus.rsp0_err   <= ~bus.PREADY;
                  bus.rsp0_rdata <= rdata_cap;
               end
            end else if (wait_cnt != {CW{1'b1}}) begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_debug_apb_arbiter.sv
// Bench for debug_apb_arbiter: directed scenarios plus a randomized run against a timeline model.
module tb_debug_apb_arbiter;
   localparam int TO = 4;
   localparam int AW = 5;

   typedef struct {
      bit         who;
      bit         wr;
      logic [4:0] a;
      logic [7:0] wd;
      int         w;
      logic [7:0] d;
   } xfer_t;

   logic PCLK;
   logic PRESETn;
   int   total;
   int   passed;
   int         plan_w[$];
   logic [7:0] plan_d[$];

   debug_apb_arbiter_if #(.ADDR_W(AW)) bus ();

   debug_apb_arbiter #(.TIMEOUT(TO), .ADDR_W(AW)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   // APB slave: each transfer stalls for the planned number of ACCESS cycles.
   initial begin : slave
      int         cur_w;
      int         acc;
      logic [7:0] cur_d;
      cur_w = 0;
      acc   = 0;
      cur_d = 8'h00;
      bus.PREADY = 1'b0;
      bus.PRDATA = 8'h00;
      forever begin
         @(negedge PCLK);
         if (bus.PSEL && !bus.PENABLE) begin
            cur_w = 0;
            cur_d = 8'($urandom);
            if (plan_w.size() > 0) begin
               cur_w = plan_w.pop_front();
               cur_d = plan_d.pop_front();
            end
            acc = 0;
            bus.PREADY = 1'b0;
            bus.PRDATA = 8'($urandom);
         end else if (bus.PSEL) begin
            bus.PREADY = (acc >= cur_w);
            bus.PRDATA = bus.PREADY ? cur_d : 8'($urandom);
            acc++;
         end else begin
            bus.PREADY = 1'b0;
            bus.PRDATA = 8'($urandom);
         end
      end
   end

   function automatic logic [23:0] obs();
      return {bus.PSEL, bus.PENABLE, bus.req0_ready, bus.req1_ready,
              bus.rsp0_valid, bus.rsp0_err, bus.rsp0_rdata,
              bus.rsp1_valid, bus.rsp1_err, bus.rsp1_rdata};
   endfunction

   function automatic logic [23:0] mk(input logic psel, input logic pen, input logic r0, input logic r1,
                                      input logic v0, input logic e0, input logic [7:0] d0,
                                      input logic v1, input logic e1, input logic [7:0] d1);
      return {psel, pen, r0, r1, v0, e0, d0, v1, e1, d1};
   endfunction

   task automatic set_req(input int who, input logic v, input logic wr, input logic [4:0] a, input logic [7:0] d);
      if (who == 0) begin
         bus.req0_valid = v; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
      end else begin
         bus.req1_valid = v; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
      end
   endtask

   task automatic do_reset();
      PRESETn = 1'b0;
      set_req(0, 1'b0, 1'b0, 5'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 5'h00, 8'h00);
      plan_w.delete();
      plan_d.delete();
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
   endtask

   task automatic test_reset();
      PRESETn = 1'b1;
      set_req(0, 1'b0, 1'b0, 5'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 5'h00, 8'h00);
      #1 PRESETn = 1'b0;
      #1;
      total++;
      if (obs() !== 24'h0) $display("FAIL reset_outputs: got %h expected %h", obs(), 24'h0);
      else passed++;
      total++;
      if ({bus.PWRITE, bus.PADDR, bus.PWDATA} !== 14'h0)
         $display("FAIL reset_bus: got %h expected %h", {bus.PWRITE, bus.PADDR, bus.PWDATA}, 14'h0);
      else passed++;
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      total++;
      if (obs() !== 24'h0) $display("FAIL idle_after_reset: got %h expected %h", obs(), 24'h0);
      else passed++;
   endtask

   // Single transfers: latency, wait states, timeout boundary, writes.
   task automatic test_transfers();
      xfer_t      tbl[7];
      int         alen;
      logic       err, setup, acc, rsp;
      logic [7:0] rd;
      logic [23:0] exp;
      tbl[0] = '{1'b0, 1'b0, 5'h00, 8'h00, 0, 8'h05};
      tbl[1] = '{1'b0, 1'b0, 5'h03, 8'h00, 3, 8'hA7};
      tbl[2] = '{1'b1, 1'b0, 5'h07, 8'h00, 9, 8'h55};
      tbl[3] = '{1'b1, 1'b0, 5'h1F, 8'h00, 0, 8'h3C};
      tbl[4] = '{1'b1, 1'b1, 5'h00, 8'h10, 0, 8'h99};
      tbl[5] = '{1'b0, 1'b1, 5'h12, 8'hEE, 3, 8'h42};
      tbl[6] = '{1'b0, 1'b0, 5'h09, 8'h00, 4, 8'h6B};
      for (int i = 0; i < 7; i++) begin
         alen = (tbl[i].w < TO) ? tbl[i].w + 1 : TO;
         err  = (tbl[i].w >= TO);
         rd   = (err || tbl[i].wr) ? 8'h00 : tbl[i].d;
         set_req(int'(tbl[i].who), 1'b1, tbl[i].wr, tbl[i].a, tbl[i].wd);
         plan_w.push_back(tbl[i].w);
         plan_d.push_back(tbl[i].d);
         for (int k = 1; k <= alen + 2; k++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            setup = (k == 1);
            acc   = (k >= 2) && (k <= alen + 1);
            rsp   = (k == alen + 2);
            exp = mk(setup || acc, acc, setup && !tbl[i].who, setup && tbl[i].who,
                     rsp && !tbl[i].who, rsp && !tbl[i].who && err, (rsp && !tbl[i].who) ? rd : 8'h00,
                     rsp && tbl[i].who, rsp && tbl[i].who && err, (rsp && tbl[i].who) ? rd : 8'h00);
            total++;
            if (obs() !== exp) $display("FAIL xfer%0d cyc%0d: got %h expected %h", i, k, obs(), exp);
            else passed++;
            if (setup) begin
               total++;
               if ({bus.PWRITE, bus.PADDR, bus.PWDATA} !== {tbl[i].wr, tbl[i].a, tbl[i].wd})
                  $display("FAIL xfer%0d fields: got %h expected %h", i,
                           {bus.PWRITE, bus.PADDR, bus.PWDATA}, {tbl[i].wr, tbl[i].a, tbl[i].wd});
               else passed++;
               set_req(int'(tbl[i].who), 1'b0, 1'b0, 5'h00, 8'h00);
            end
         end
      end
   endtask

   task automatic test_contention();
      int   grants[$];
      int   low_run, min_gap, both;
      logic prev_pen, seen_high;
      PRESETn = 1'b0;
      set_req(0, 1'b1, 1'b0, 5'h0A, 8'h11);
      set_req(1, 1'b1, 1'b1, 5'h15, 8'h22);
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      low_run = 0; min_gap = 99; both = 0; prev_pen = 1'b0; seen_high = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge PCLK);
         @(negedge PCLK);
         if (bus.req0_ready && bus.req1_ready) both++;
         if (bus.req0_ready || bus.req1_ready) begin
            grants.push_back(bus.req1_ready ? 1 : 0);
            total++;
            if (bus.PADDR !== (bus.req1_ready ? 5'h15 : 5'h0A))
               $display("FAIL contention_addr cyc%0d: got %h expected %h", k, bus.PADDR,
                        bus.req1_ready ? 5'h15 : 5'h0A);
            else passed++;
            if (grants.size() == 4) begin
               set_req(0, 1'b0, 1'b0, 5'h00, 8'h00);
               set_req(1, 1'b0, 1'b0, 5'h00, 8'h00);
            end
         end
         if (bus.PENABLE && !prev_pen && seen_high && low_run < min_gap) min_gap = low_run;
         if (bus.PENABLE) begin
            seen_high = 1'b1;
            low_run = 0;
         end else begin
            low_run++;
         end
         prev_pen = bus.PENABLE;
      end
      total++;
      if (grants.size() != 4) $display("FAIL contention_count: got %0d expected 4", grants.size());
      else passed++;
      for (int i = 0; i < grants.size() && i < 4; i++) begin
         total++;
         if (grants[i] != (i % 2)) $display("FAIL contention_order%0d: got %0d expected %0d", i, grants[i], i % 2);
         else passed++;
      end
      total++;
      if (min_gap < 2) $display("FAIL penable_gap: got %0d expected >=2", min_gap);
      else passed++;
      total++;
      if (both != 0) $display("FAIL dual_ready: got %0d expected 0", both);
      else passed++;
   endtask

   task automatic test_reset_mid_access();
      set_req(0, 1'b1, 1'b0, 5'h04, 8'h00);
      plan_w.push_back(9);
      plan_d.push_back(8'h77);
      repeat (2) begin
         @(posedge PCLK);
         @(negedge PCLK);
      end
      #1 PRESETn = 1'b0;
      #1;
      total++;
      if (obs() !== 24'h0) $display("FAIL async_reset: got %h expected %h", obs(), 24'h0);
      else passed++;
      total++;
      if ({bus.PWRITE, bus.PADDR, bus.PWDATA} !== 14'h0)
         $display("FAIL async_reset_bus: got %h expected %h", {bus.PWRITE, bus.PADDR, bus.PWDATA}, 14'h0);
      else passed++;
      set_req(1, 1'b1, 1'b0, 5'h06, 8'h00);
      repeat (2) @(negedge PCLK);
      total++;
      if (obs() !== 24'h0) $display("FAIL no_rsp_in_reset: got %h expected %h", obs(), 24'h0);
      else passed++;
      PRESETn = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
      total++;
      if (obs() !== mk(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00))
         $display("FAIL post_reset_grant: got %h expected %h", obs(), mk(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00));
      else passed++;
      set_req(0, 1'b0, 1'b0, 5'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 5'h00, 8'h00);
      repeat (4) @(negedge PCLK);
   endtask

   // Timeline model: a grant at edge t0 occupies the bus until edge t0+alen+2.
   task automatic test_random();
      int          next_free, t0, alen, w;
      logic        active, last, who, exp_err, exp_wr;
      logic        setup, acc, rsp;
      logic [4:0]  exp_a;
      logic [7:0]  exp_wd, exp_rd, d;
      logic [23:0] exp;
      do_reset();
      last = 1'b1; active = 1'b0; next_free = 0; t0 = 0; alen = 0;
      who = 1'b0; exp_err = 1'b0; exp_wr = 1'b0; exp_a = '0; exp_wd = '0; exp_rd = '0;
      for (int e = 0; e < 1500; e++) begin
         @(posedge PCLK);
         #1;
         if (e >= next_free && (bus.req0_valid || bus.req1_valid)) begin
            who = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;
            last = who;
            t0 = e;
            active = 1'b1;
            w = $urandom_range(0, 6);
            d = 8'($urandom);
            plan_w.push_back(w);
            plan_d.push_back(d);
            exp_wr = who ? bus.req1_write : bus.req0_write;
            exp_a  = who ? bus.req1_addr  : bus.req0_addr;
            exp_wd = who ? bus.req1_wdata : bus.req0_wdata;
            alen    = (w < TO) ? w + 1 : TO;
            exp_err = (w >= TO);
            exp_rd  = (exp_err || exp_wr) ? 8'h00 : d;
            next_free = e + alen + 2;
         end
         setup = active && (e == t0);
         acc   = active && (e > t0) && (e <= t0 + alen);
         rsp   = active && (e == t0 + alen + 1);
         exp = mk(setup || acc, acc, setup && !who, setup && who,
                  rsp && !who, rsp && !who && exp_err, (rsp && !who) ? exp_rd : 8'h00,
                  rsp && who, rsp && who && exp_err, (rsp && who) ? exp_rd : 8'h00);
         @(negedge PCLK);
         total++;
         if (obs() !== exp) $display("FAIL rand e%0d: got %h expected %h", e, obs(), exp);
         else passed++;
         if (setup || acc) begin
            total++;
            if ({bus.PWRITE, bus.PADDR, bus.PWDATA} !== {exp_wr, exp_a, exp_wd})
               $display("FAIL rand_fields e%0d: got %h expected %h", e,
                        {bus.PWRITE, bus.PADDR, bus.PWDATA}, {exp_wr, exp_a, exp_wd});
            else passed++;
         end
         if (bus.req0_valid && bus.req0_ready) bus.req0_valid = 1'b0;
         if (bus.req1_valid && bus.req1_ready) bus.req1_valid = 1'b0;
         if (!bus.req0_valid && $urandom_range(0, 1) == 1)
            set_req(0, 1'b1, 1'($urandom), 5'($urandom), 8'($urandom));
         if (!bus.req1_valid && $urandom_range(0, 1) == 1)
            set_req(1, 1'b1, 1'($urandom), 5'($urandom), 8'($urandom));
      end
   endtask

   initial begin
      total  = 0;
      passed = 0;
      test_reset();
      test_transfers();
      test_contention();
      test_reset_mid_access();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
